mult_share_ctrl: RTL and testbench

//  Round-robin controller sharing one repeated-addition multiplier (start/done, 8x8->16) among N_REQ requesters.

---
 rtl/mult_share_ctrl.sv | 136 +++++++++++++
 tb/tb_mult_share_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one start/done repeated-addition multiplier
// among N_REQ requesters, with zero short-circuit and a WAIT-state watchdog.
module mult_share_ctrl #(
    parameter int N_REQ       = 4,
    parameter int W           = 8,
    parameter int TIMEOUT_CYC = 270
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       a_in,
    input  logic [N_REQ*W-1:0]       b_in,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [2*W-1:0]           rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     mul_start,
    output logic [W-1:0]             mul_a,
    output logic [W-1:0]             mul_b,
    input  logic [2*W-1:0]           mul_out,
    input  logic                     mul_done
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  ptr, id_q, g;
    logic             found;
    logic [W-1:0]     a_q, b_q;
    logic [WD_W-1:0]  wd;
    logic             zero_op, done_ok, tmo;
    logic [N_REQ-1:0] gnt_nxt;
    logic             start_nxt, valid_nxt;

    // Rotating-priority search starting at ptr.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        g     = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                g     = idx[ID_W-1:0];
            end
        end
    end

    assign zero_op = (a_q == '0) || (b_q == '0);
    // First WAIT cycle (wd==0) ignores a possibly stale done level.
    assign done_ok = (wd != '0) && mul_done;
    assign tmo     = (wd == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = LOAD;
            LOAD:    state_nxt = zero_op ? RESP : START;
            START:   state_nxt = WAIT;
            WAIT:    if (done_ok || tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt = '0;
        if (state == IDLE && found) gnt_nxt[g] = 1'b1;
        start_nxt = (state == LOAD) && !zero_op;
        valid_nxt = (state_nxt == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wd        <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            busy      <= (state_nxt != IDLE);
            mul_start <= start_nxt;
            rsp_valid <= valid_nxt;
            case (state)
                IDLE: if (found) begin
                    id_q <= g;
                    a_q  <= a_in[g*W +: W];
                    b_q  <= b_in[g*W +: W];
                    ptr  <= (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
                end
                LOAD: if (zero_op) begin
                    rsp_id   <= id_q;
                    rsp_data <= '0;
                    rsp_err  <= 1'b0;
                end else begin
                    // Smaller operand drives the iteration count.
                    mul_a <= (a_q >= b_q) ? a_q : b_q;
                    mul_b <= (a_q >= b_q) ? b_q : a_q;
                end
                START: wd <= '0;
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (done_ok) begin
                        rsp_id   <= id_q;
                        rsp_data <= mul_out;
                        rsp_err  <= 1'b0;
                    end else if (tmo) begin
                        rsp_id   <= id_q;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl with a behavioural repeated-addition
// multiplier that can be forced to hang.
module tb_mult_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] a_in = '0, b_in = '0;
    logic [3:0]  gnt;
    logic        rsp_valid, rsp_err, busy, mul_start, mul_done;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data, mul_out;
    logic [7:0]  mul_a, mul_b;

    mult_share_ctrl #(.N_REQ(4), .W(8), .TIMEOUT_CYC(270)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_out(mul_out), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    // External multiplier: loads on start, adds mul_a once per cycle, mul_b times.
    logic [15:0] m_acc = '0;
    logic [7:0]  m_cnt = '0;
    logic        m_run = 1'b0;
    bit          mul_dead = 1'b0;
    always @(posedge clk) begin
        if (mul_start) begin
            m_acc <= '0;
            m_cnt <= mul_b;
            m_run <= 1'b1;
        end else if (m_run && m_cnt != 0) begin
            m_acc <= m_acc + 16'(mul_a);
            m_cnt <= m_cnt - 8'd1;
        end
    end
    assign mul_done = m_run && (m_cnt == 0) && !mul_dead;
    assign mul_out  = m_acc;

    typedef struct { int id; int data; int err; int lat; } exp_t;
    exp_t exp_rsp[$];
    int   exp_gnt[$];
    int   gcyc[$];
    int   cyc = 0;
    int   n_checks = 0, n_fail = 0, n_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not as expected (got 1 expected 0)", name);
    endtask

    // Monitor: pops expectations whenever the DUT presents gnt or rsp_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_start) n_start++;
            if (gnt != 0) begin
                if (exp_gnt.size() == 0) fail_now("gnt_unexpected");
                else begin
                    int e;
                    e = exp_gnt.pop_front();
                    check("gnt", int'(gnt), 1 << e);
                end
                gcyc.push_back(cyc);
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0 || gcyc.size() == 0) fail_now("rsp_unexpected");
                else begin
                    exp_t e;
                    int   g0;
                    e  = exp_rsp.pop_front();
                    g0 = gcyc.pop_front();
                    check("rsp_id",   int'(rsp_id),   e.id);
                    check("rsp_data", int'(rsp_data), e.data);
                    check("rsp_err",  int'(rsp_err),  e.err);
                    check("latency",  cyc - g0,       e.lat);
                end
            end
        end
    end

    task automatic issue(int id, int a, int b, int data, int err, int lat);
        int n;
        exp_gnt.push_back(id);
        exp_rsp.push_back('{id, data, err, lat});
        a_in[id*8 +: 8] = 8'(a);
        b_in[id*8 +: 8] = 8'(b);
        req[id] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[id] && n < 50);
        if (!gnt[id]) fail_now("gnt_timeout");
        req[id] = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_rsp.size() != 0 || busy) fail_now("idle_timeout");
        @(negedge clk);
    endtask

    initial begin
        int n, k, s0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_gnt", int'(gnt), 0);
        check("reset_valid", int'(rsp_valid), 0);
        check("reset_start", int'(mul_start), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 7x3 on requester 0
        issue(0, 7, 3, 21, 0, 6);
        wait_idle(50);
        repeat (3) @(negedge clk);
        check("hold_data", int'(rsp_data), 21);
        check("hold_id", int'(rsp_id), 0);
        check("hold_valid", int'(rsp_valid), 0);

        // 2: operand swap 2x200 on requester 2
        issue(2, 2, 200, 400, 0, 5);
        n = 0;
        while (!mul_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!mul_start) fail_now("start_timeout");
        check("mul_a", int'(mul_a), 200);
        check("mul_b", int'(mul_b), 2);
        wait_idle(50);

        // 3: zero operand short-circuit on requester 1
        s0 = n_start;
        issue(1, 0, 255, 0, 0, 1);
        wait_idle(50);
        check("zero_no_start", n_start - s0, 0);

        // 5: hung multiplier times out, then the next request is served
        mul_dead = 1'b1;
        issue(0, 5, 5, 0, 1, 272);
        wait_idle(400);
        mul_dead = 1'b0;
        issue(1, 3, 4, 12, 0, 6);
        wait_idle(50);

        // 6: reset in the middle of WAIT, then 255x255 on requester 3
        issue(2, 100, 100, 10000, 0, 103);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(mul_start), 0);
        check("rst_mul_a", int'(mul_a), 0);
        check("rst_mul_b", int'(mul_b), 0);
        check("rst_data", int'(rsp_data), 0);
        check("rst_gnt", int'(gnt), 0);
        exp_rsp.delete();
        exp_gnt.delete();
        gcyc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3, 255, 255, 65025, 0, 258);
        wait_idle(400);

        // 4: all requesters held, round-robin from pointer 0
        a_in = 32'h01010101;
        b_in = 32'h01010101;
        for (int i = 0; i < 5; i++) begin
            exp_gnt.push_back(i % 4);
            exp_rsp.push_back('{i % 4, 1, 0, 4});
        end
        req = 4'hF;
        k = 0;
        n = 0;
        while (k < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (gnt != 0) k++;
        end
        req = '0;
        check("rr_grants", k, 5);
        wait_idle(100);
        check("queues_drained", exp_gnt.size() + exp_rsp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
